// File: rtl/dual_port_arb.sv
// Round-robin arbiter sharing RAM port A between NREQ requesters.
// It adds byte-enable writes by doing an internal read-modify-write and returns tagged read data.
module dual_port_arb #(
    parameter int NREQ = 4,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      we,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*DW-1:0]   wdata,
    input  logic [NREQ*4-1:0]    be,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      rvalid,
    output logic [DW-1:0]        rdata,
    output logic [AW-1:0]        ram_addr,
    output logic [DW-1:0]        ram_data,
    output logic                 ram_wren,
    input  logic [DW-1:0]        ram_q
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WR, RD, RDQ} state_t;

    state_t          state, state_d;
    logic [IW-1:0]   ptr, ptr_d;
    logic [IW-1:0]   cur_idx, cur_idx_d;
    logic            cur_we, cur_we_d;
    logic [DW-1:0]   cur_wdata, cur_wdata_d;
    logic [3:0]      cur_be, cur_be_d;

    logic [NREQ-1:0] ack_d, rvalid_d;
    logic [DW-1:0]   rdata_d, ram_data_d;
    logic [AW-1:0]   ram_addr_d;
    logic            ram_wren_d;

    logic [AW-1:0]   addr_a  [NREQ];
    logic [DW-1:0]   wdata_a [NREQ];
    logic [3:0]      be_a    [NREQ];

    logic [IW-1:0]   win;
    logic [IW:0]     cand;
    logic            found;
    logic [DW-1:0]   merged;

    for (genvar g = 0; g < NREQ; g++) begin : g_split
        assign addr_a[g]  = addr[g*AW +: AW];
        assign wdata_a[g] = wdata[g*DW +: DW];
        assign be_a[g]    = be[g*4 +: 4];
    end

    // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                win   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        merged = ram_q;
        for (int k = 0; k < 4; k++) begin
            if (cur_be[k]) merged[8*k +: 8] = cur_wdata[8*k +: 8];
        end
    end

    always_comb begin
        // NOTE: every value driven here gets a default first, so no latch can be inferred.
        state_d     = state;
        ptr_d       = ptr;
        cur_idx_d   = cur_idx;
        cur_we_d    = cur_we;
        cur_wdata_d = cur_wdata;
        cur_be_d    = cur_be;
        ack_d       = '0;
        rvalid_d    = '0;
        rdata_d     = rdata;
        ram_addr_d  = ram_addr;
        ram_data_d  = ram_data;
        ram_wren_d  = 1'b0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    cur_idx_d   = win;
                    cur_we_d    = we[win];
                    cur_wdata_d = wdata_a[win];
                    cur_be_d    = be_a[win];
                    ptr_d       = (win == IW'(NREQ-1)) ? '0 : win + 1'b1;
                    ack_d[win]  = 1'b1;
                    ram_addr_d  = addr_a[win];
                    if (we[win] && be_a[win] == 4'hF) begin
                        ram_data_d = wdata_a[win];
                        ram_wren_d = 1'b1;
                        state_d    = WR;
                    end else if (we[win] && be_a[win] == 4'h0) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            WR:  state_d = IDLE;
            RD:  state_d = RDQ;
            RDQ: begin
                // A write that reached RDQ is partial: merge and write back.
                if (cur_we) begin
                    ram_data_d = merged;
                    ram_wren_d = 1'b1;
                    state_d    = WR;
                end else begin
                    rdata_d           = ram_q;
                    rvalid_d[cur_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            cur_idx   <= '0;
            cur_we    <= 1'b0;
            cur_wdata <= '0;
            cur_be    <= '0;
            ack       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            ram_addr  <= '0;
            ram_data  <= '0;
            ram_wren  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state     <= state_d;
            ptr       <= ptr_d;
            cur_idx   <= cur_idx_d;
            cur_we    <= cur_we_d;
            cur_wdata <= cur_wdata_d;
            cur_be    <= cur_be_d;
            ack       <= ack_d;
            rvalid    <= rvalid_d;
            rdata     <= rdata_d;
            ram_addr  <= ram_addr_d;
            ram_data  <= ram_data_d;
            ram_wren  <= ram_wren_d;
        end
    end

endmodule

// File: tb/tb_dual_port_arb.sv
// Scoreboard bench for dual_port_arb with a behavioural registered-read RAM on port A.
// Stimulus pushes expected acks, read returns and RAM writes; a monitor pops and compares them.
module tb_dual_port_arb;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                preload = 1'b1;
    logic [NREQ-1:0]     req, we;
    logic [NREQ*AW-1:0]  addr;
    logic [NREQ*DW-1:0]  wdata;
    logic [NREQ*4-1:0]   be;
    logic [NREQ-1:0]     ack, rvalid;
    logic [DW-1:0]       rdata, ram_data, ram_q;
    logic [AW-1:0]       ram_addr;
    logic                ram_wren;
    logic [DW-1:0]       mem [32];

    typedef struct { int idx; bit is_read; } ack_exp_t;
    typedef struct { int idx; logic [31:0] data; } rd_exp_t;
    typedef struct { logic [AW-1:0] a; logic [31:0] data; } wr_exp_t;

    ack_exp_t exp_ack [$];
    rd_exp_t  exp_rd  [$];
    wr_exp_t  exp_wr  [$];
    int       rd_ack_cyc [$];

    ack_exp_t ae;
    rd_exp_t  re;
    wr_exp_t  wx;
    int       n_checks = 0;
    int       n_pass   = 0;
    int       cycle    = 0;
    int       lat;

    dual_port_arb #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .be       (be),
        .ack      (ack),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycle++;

    function automatic logic [31:0] init_word(int k);
        case (k)
            3:       return 32'h1122_3344;
            7:       return 32'h0000_0000;
            default: return 32'hC0DE_0000 | 32'(k);
        endcase
    endfunction

    always @(posedge clock) begin
        if (preload) begin
            for (int k = 0; k < 32; k++) mem[k] <= init_word(k);
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic unexpected(string name, logic [31:0] act);
        n_checks++;
        $display("FAIL %s: got %h, required no event", name, act);
    endtask

    task automatic set_req(int i, logic w, logic [AW-1:0] a, logic [31:0] d, logic [3:0] b);
        req[i]            = 1'b1;
        we[i]             = w;
        addr[i*AW +: AW]  = a;
        wdata[i*32 +: 32] = d;
        be[i*4 +: 4]      = b;
    endtask

    task automatic exp_read(int i, logic [31:0] d);
        exp_ack.push_back('{i, 1'b1});
        exp_rd.push_back('{i, d});
    endtask

    task automatic exp_write(int i, logic [AW-1:0] a, logic [31:0] d);
        exp_ack.push_back('{i, 1'b0});
        exp_wr.push_back('{a, d});
    endtask

    task automatic exp_nop(int i);
        exp_ack.push_back('{i, 1'b0});
    endtask

    task automatic wait_ack(int i, output int n);
        n = 0;
        while (n < 64) begin
            @(negedge clock);
            n++;
            if (ack[i]) return;
        end
        n_checks++;
        $display("FAIL ack_timeout: requester %0d got no ack, required one within 64 cycles", i);
    endtask

    task automatic serve(int i);
        int n;
        wait_ack(i, n);
        @(posedge clock);
        #1;
        req[i] = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (t < 100 && (exp_ack.size() + exp_rd.size() + exp_wr.size()) != 0) begin
            @(negedge clock);
            t++;
        end
        if ((exp_ack.size() + exp_rd.size() + exp_wr.size()) != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d events outstanding, required 0",
                     exp_ack.size() + exp_rd.size() + exp_wr.size());
        end
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ack"},      32'(ack),      32'h0);
        check({tag, "_rvalid"},   32'(rvalid),   32'h0);
        check({tag, "_rdata"},    rdata,         32'h0);
        check({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
        check({tag, "_ram_data"}, ram_data,      32'h0);
        check({tag, "_ram_wren"}, 32'(ram_wren), 32'h0);
    endtask

    // Monitor: every DUT output event must match the head of its expectation queue.
    initial begin
        forever begin
            @(negedge clock);
            if (ack !== '0) begin
                if (exp_ack.size() == 0) unexpected("ack_event", 32'(ack));
                else begin
                    ae = exp_ack.pop_front();
                    check("ack_onehot", 32'(ack), 32'(1) << ae.idx);
                    if (ae.is_read) rd_ack_cyc.push_back(cycle);
                end
            end
            if (rvalid !== '0) begin
                if (exp_rd.size() == 0) unexpected("rvalid_event", 32'(rvalid));
                else begin
                    re = exp_rd.pop_front();
                    check("rvalid_onehot", 32'(rvalid), 32'(1) << re.idx);
                    check("rdata", rdata, re.data);
                    if (rd_ack_cyc.size() != 0) begin
                        lat = cycle - rd_ack_cyc.pop_front();
                        check("rvalid_latency", 32'(lat), 32'd2);
                    end
                end
            end
            if (ram_wren !== 1'b0) begin
                if (exp_wr.size() == 0) unexpected("ram_wren_event", 32'(ram_addr));
                else begin
                    wx = exp_wr.pop_front();
                    check("wren_addr", 32'(ram_addr), 32'(wx.a));
                    check("wren_data", ram_data, wx.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req = '0; we = '0; addr = '0; wdata = '0; be = '0;
        @(negedge clock);
        preload = 1'b0;
        @(negedge clock);
        check_reset_outputs("reset");

        // Four reads held from reset, then requester 0 re-requests behind 1..3.
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, AW'(i), 32'h0, (i % 2 == 1) ? 4'hF : 4'h0);
        exp_read(0, 32'hC0DE_0000);
        exp_read(1, 32'hC0DE_0001);
        exp_read(2, 32'hC0DE_0002);
        exp_read(3, 32'h1122_3344);
        exp_read(0, 32'hC0DE_0004);
        reset = 1'b0;
        wait_ack(0, n);
        @(posedge clock);
        #1;
        set_req(0, 1'b0, 5'd4, 32'h0, 4'hF);
        serve(1);
        serve(2);
        serve(3);
        serve(0);
        drain();

        // Full write then read-back by requester 0.
        set_req(0, 1'b1, 5'd5, 32'hDEAD_BEEF, 4'hF);
        exp_write(0, 5'd5, 32'hDEAD_BEEF);
        wait_ack(0, n);
        check("full_wr_ack_delay", 32'(n), 32'd2);
        check("full_wr_wren_with_ack", 32'(ram_wren), 32'h1);
        check("full_wr_addr_with_ack", 32'(ram_addr), 32'd5);
        @(posedge clock);
        #1;
        req[0] = 1'b0;
        drain();
        set_req(0, 1'b0, 5'd5, 32'h0, 4'h0);
        exp_read(0, 32'hDEAD_BEEF);
        serve(0);
        drain();

        // Partial write merges bytes 0 and 2 into 32'h11223344.
        set_req(2, 1'b1, 5'd3, 32'hAABB_CCDD, 4'b0101);
        exp_write(2, 5'd3, 32'h11BB_33DD);
        serve(2);
        drain();
        set_req(2, 1'b0, 5'd3, 32'h0, 4'h0);
        exp_read(2, 32'h11BB_33DD);
        serve(2);
        drain();

        // Grant to requester 1 leaves the pointer at 2; then 1 and 3 request together.
        set_req(1, 1'b0, 5'd0, 32'h0, 4'h0);
        exp_read(1, 32'hC0DE_0000);
        serve(1);
        drain();
        set_req(1, 1'b0, 5'd1, 32'h0, 4'h0);
        set_req(3, 1'b0, 5'd2, 32'h0, 4'h0);
        exp_read(3, 32'hC0DE_0002);
        exp_read(1, 32'hC0DE_0001);
        serve(3);
        serve(1);
        drain();

        // Write with no byte enables: acknowledged, RAM untouched.
        set_req(0, 1'b1, 5'd9, 32'hFFFF_FFFF, 4'h0);
        exp_nop(0);
        wait_ack(0, n);
        check("nop_wr_no_wren", 32'(ram_wren), 32'h0);
        @(posedge clock);
        #1;
        req[0] = 1'b0;
        drain();
        check("nop_wr_mem9", mem[9], 32'hC0DE_0009);
        set_req(0, 1'b0, 5'd9, 32'h0, 4'h0);
        exp_read(0, 32'hC0DE_0009);
        serve(0);
        drain();

        // Top address followed by address 0.
        set_req(1, 1'b1, 5'd31, 32'h3131_3131, 4'hF);
        exp_write(1, 5'd31, 32'h3131_3131);
        serve(1);
        drain();
        set_req(1, 1'b1, 5'd0, 32'hA0A0_A0A0, 4'hF);
        exp_write(1, 5'd0, 32'hA0A0_A0A0);
        serve(1);
        drain();
        set_req(1, 1'b0, 5'd31, 32'h0, 4'h0);
        exp_read(1, 32'h3131_3131);
        serve(1);
        drain();
        set_req(1, 1'b0, 5'd0, 32'h0, 4'h0);
        exp_read(1, 32'hA0A0_A0A0);
        serve(1);
        drain();

        // Reset lands in RDQ of a partial write to address 7: the write must be lost.
        set_req(0, 1'b1, 5'd7, 32'hFFFF_FFFF, 4'b0011);
        exp_nop(0);
        wait_ack(0, n);
        @(posedge clock);
        #1;
        req[0] = 1'b0;
        reset  = 1'b1;
        #1;
        check_reset_outputs("mid_op_reset");
        repeat (3) @(negedge clock);
        check("mid_op_reset_mem7", mem[7], 32'h0);
        reset = 1'b0;

        // Pointer is back at 0, so requester 1 wins over 3.
        set_req(1, 1'b0, 5'd31, 32'h0, 4'h0);
        set_req(3, 1'b0, 5'd7, 32'h0, 4'h0);
        exp_read(1, 32'h3131_3131);
        exp_read(3, 32'h0000_0000);
        serve(1);
        serve(3);
        drain();

        check("sb_ack_left", 32'(exp_ack.size()), 32'h0);
        check("sb_rd_left",  32'(exp_rd.size()),  32'h0);
        check("sb_wr_left",  32'(exp_wr.size()),  32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
